// File: rtl/dcp_rx_scan.sv
// dcp_rx_scan: scans the UART byte stream for one command character or one hex word per request.
// A one-deep hold buffer catches bytes that arrive while no scan is consuming them.
module dcp_rx_scan #(
    parameter int WORD_W     = 32,
    parameter int MAX_DIGITS = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rx_vld,
    input  logic [7:0]        rx_data,
    input  logic              req_rx,
    input  logic              type_rx,
    output logic              ack_rx,
    output logic              flag_rx,
    output logic [WORD_W-1:0] din_rx,
    output logic              ovf
);
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0] MAXC = CW'(MAX_DIGITS);
    typedef enum logic [1:0] {IDLE, CHAR, WORD, DONE} state_t;
    state_t state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic hold_vld_q, hold_vld_d;
    logic [WORD_W-1:0] acc_q, acc_d, din_q, din_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic bad_q, bad_d, ack_q, ack_d, flag_q, flag_d, ovf_q, ovf_d;
    logic scan, take, is_num, is_hex, is_sep;
    logic [7:0] b, uc;
    logic [3:0] nib;
    assign scan   = (state_q == CHAR || state_q == WORD) && req_rx;
    assign take   = scan && (hold_vld_q || rx_vld);
    assign b      = hold_vld_q ? hold_q : rx_data;
    assign is_num = b >= 8'h30 && b <= 8'h39;
    assign is_hex = is_num || (b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66);
    assign nib    = is_num ? b[3:0] : b[3:0] + 4'd9;
    assign is_sep = b == 8'h20 || b == 8'h0D || b == 8'h0A;
    assign uc     = (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        bad_d      = bad_q;
        din_d      = din_q;
        flag_d     = flag_q;
        ovf_d      = ovf_q;
        ack_d      = 1'b0;
        // held byte is consumed first; a live byte in the same cycle refills the buffer
        if (take && hold_vld_q) begin
            hold_vld_d = rx_vld;
            hold_d     = rx_data;
        end else if (rx_vld && !take) begin
            hold_vld_d = 1'b1;
            hold_d     = rx_data;
            ovf_d      = ovf_q | hold_vld_q;
        end
        case (state_q)
            IDLE: if (req_rx) begin
                state_d = type_rx ? WORD : CHAR;
                acc_d   = '0;
                cnt_d   = '0;
                bad_d   = 1'b0;
            end
            CHAR: if (!req_rx) state_d = IDLE;
            else if (take && !is_sep) begin
                din_d   = WORD_W'(uc);
                flag_d  = 1'b0;
                ack_d   = 1'b1;
                state_d = DONE;
            end
            WORD: if (!req_rx) begin
                state_d = IDLE;
                acc_d   = '0;
                cnt_d   = '0;
                bad_d   = 1'b0;
            end else if (take) begin
                if (!is_sep) begin
                    acc_d = is_hex ? {acc_q[WORD_W-5:0], nib} : acc_q;
                    cnt_d = (cnt_q >= MAXC) ? cnt_q : cnt_q + 1'b1;
                    bad_d = bad_q || !is_hex || cnt_q >= MAXC;
                end else if (cnt_q != '0) begin
                    din_d   = acc_q;
                    flag_d  = bad_q;
                    ack_d   = 1'b1;
                    state_d = DONE;
                end else if (b == 8'h0D) begin
                    din_d   = '0;
                    flag_d  = 1'b1;
                    ack_d   = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            bad_q      <= 1'b0;
            din_q      <= '0;
            flag_q     <= 1'b0;
            ack_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            bad_q      <= bad_d;
            din_q      <= din_d;
            flag_q     <= flag_d;
            ack_q      <= ack_d;
            ovf_q      <= ovf_d;
        end
    end
    assign ack_rx  = ack_q;
    assign flag_rx = flag_q;
    assign din_rx  = din_q;
    assign ovf     = ovf_q;
endmodule

// File: tb/tb_dcp_rx_scan.sv
// tb_dcp_rx_scan: directed byte streams into dcp_rx_scan with hand-computed results.
module tb_dcp_rx_scan;
    logic clk = 1'b0, rstn = 1'b0, rx_vld = 1'b0, req_rx = 1'b0, type_rx = 1'b0;
    logic [7:0] rx_data = '0;
    logic ack_rx, flag_rx, ovf;
    logic [31:0] din_rx;
    int checks = 0, errors = 0;
    logic [31:0] dq[$];
    logic fq[$];
    logic prev_ack = 1'b0;

    dcp_rx_scan dut (
        .clk(clk), .rstn(rstn), .rx_vld(rx_vld), .rx_data(rx_data), .req_rx(req_rx),
        .type_rx(type_rx), .ack_rx(ack_rx), .flag_rx(flag_rx), .din_rx(din_rx), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ack_rx) begin
            chk("ack_single", {31'b0, prev_ack}, 32'd0);
            dq.push_back(din_rx);
            fq.push_back(flag_rx);
        end
        prev_ack = ack_rx;
    end

    task automatic sendb(input logic [7:0] c);
        @(negedge clk);
        rx_vld = 1'b1;
        rx_data = c;
        @(negedge clk);
        rx_vld = 1'b0;
    endtask

    task automatic scan(input logic t, input string s);
        dq.delete();
        fq.delete();
        @(negedge clk);
        req_rx = 1'b1;
        type_rx = t;
        for (int i = 0; i < s.len(); i++) sendb(s[i]);
        repeat (6) @(negedge clk);
        req_rx = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_ack(input string tag, input logic [31:0] d, input logic f);
        chk({tag, "_present"}, {31'b0, dq.size() > 0}, 32'd1);
        if (dq.size() > 0) begin
            chk({tag, "_din"}, dq.pop_front(), d);
            chk({tag, "_flag"}, {31'b0, fq.pop_front()}, {31'b0, f});
        end
    endtask

    initial begin
        #1;
        chk("rst_ack", {31'b0, ack_rx}, 0);
        chk("rst_din", din_rx, 0);
        chk("rst_ovf", {31'b0, ovf}, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        scan(1'b0, " d");
        chk("char_n", dq.size(), 1);
        expect_ack("char", 32'h44, 1'b0);

        scan(1'b1, "1234abcd\r");
        chk("word_n", dq.size(), 1);
        expect_ack("word", 32'h1234ABCD, 1'b0);
        scan(1'b1, "\n\r\n");
        chk("null_n", dq.size(), 1);
        expect_ack("null", 32'h0, 1'b1);

        scan(1'b1, "123456789 ");
        chk("long_n", dq.size(), 1);
        chk("long_present", {31'b0, fq.size() > 0}, 1);
        if (fq.size() > 0) chk("long_flag", {31'b0, fq[0]}, 1);
        scan(1'b1, "1G2 ");
        chk("badc_present", {31'b0, fq.size() > 0}, 1);
        if (fq.size() > 0) chk("badc_flag", {31'b0, fq[0]}, 1);
        scan(1'b1, "  7F\n");
        expect_ack("7f", 32'h7F, 1'b0);

        scan(1'b1, "11\r\n22\r\n\r\n\r\n");
        chk("loop_n", dq.size(), 4);
        expect_ack("loop0", 32'h11, 1'b0);
        expect_ack("loop1", 32'h22, 1'b0);
        expect_ack("loop2", 32'h0, 1'b1);
        expect_ack("loop3", 32'h0, 1'b1);
        chk("loop_ovf", {31'b0, ovf}, 0);

        sendb("X");
        sendb("Y");
        @(negedge clk);
        chk("ovf_set", {31'b0, ovf}, 1);
        scan(1'b0, "");
        chk("held_n", dq.size(), 1);
        expect_ack("held", 32'h59, 1'b0);

        @(negedge clk);
        req_rx = 1'b1;
        type_rx = 1'b1;
        sendb("A");
        sendb("B");
        rstn = 1'b0;
        req_rx = 1'b0;
        #1;
        chk("mid_rst_ack", {31'b0, ack_rx}, 0);
        chk("mid_rst_flag", {31'b0, flag_rx}, 0);
        chk("mid_rst_din", din_rx, 0);
        chk("mid_rst_ovf", {31'b0, ovf}, 0);
        @(negedge clk);
        rstn = 1'b1;
        scan(1'b1, "C\r");
        chk("post_rst_n", dq.size(), 1);
        expect_ack("post_rst", 32'hC, 1'b0);

        dq.delete();
        fq.delete();
        @(negedge clk);
        req_rx = 1'b1;
        type_rx = 1'b1;
        sendb("5");
        req_rx = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_no_ack", dq.size(), 0);
        scan(1'b1, "\r");
        expect_ack("abort_clr", 32'h0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
